i2s_sample_tx: RTL and testbench
================================

# i2s_sample_tx

Output stage of the MP3 music player. It sits directly downstream of `music_player` and consumes each `sample_out`/`new_sample_generated` pair into a 4-deep FIFO. It serialises the samples as 16-bit I2S to the audio DAC, sending the same mono word on both channels. Once per audio frame it returns a one-cycle `new_frame` request upstream, which paces the decoder.

## Interface
- `BCLK_DIV`, default 4: clk cycles per BCLK half-period. Must be ≥2. Frame period = 64·BCLK_DIV clk cycles.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: level-sensitive run request.
- `sample_in` input, 16 bits: signed PCM sample. Connects to `sample_out`.
- `sample_valid` input, 1 bit: single-cycle push strobe. Connects to `new_sample_generated`.
- `clear_flags` input, 1 bit: synchronous clear of the sticky flags.
- `new_frame` output, 1 bit: one-cycle request for the next sample.
- `i2s_bclk` output, 1 bit: bit clock.
- `i2s_lrclk` output, 1 bit: word select. 0 = left, 1 = right.
- `i2s_sdata` output, 1 bit: serial data, MSB first.
- `fifo_level` output, 3 bits: FIFO occupancy, 0–4.
- `underrun` output, 1 bit: sticky flag. The FIFO was empty at a frame start.
- `overflow` output, 1 bit: sticky flag. A push was dropped because the FIFO was full.

## Operation
- Reset (`reset`=0):
  - FSM goes to IDLE.
  - FIFO is emptied.
  - Every output is 0.
  - div_cnt=0, bit_cnt=0, shift register=0.
- FSM has three states:
  - IDLE: `i2s_bclk`, `i2s_lrclk` and `i2s_sdata` are held at 0. `enable`=1 → RUN, with a frame-start event in that same cycle.
  - RUN: normal serialisation. `enable`=0 → STOP.
  - STOP: serialisation continues. At the next frame boundary (bit 31 → 0) the FSM goes to IDLE instead of starting a frame. No pop and no `new_frame` occur at that boundary. `enable`=1 while in STOP → RUN, with no gap in the stream.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 in RUN and STOP.
  - At terminal count, `i2s_bclk` toggles and div_cnt wraps to 0.
  - On a falling toggle, bit_cnt advances by 1 (mod 32) and the shift register shifts left.
- Frame-start event: the falling toggle where bit_cnt wraps 31 → 0, or IDLE → RUN entry.
  - The FIFO head is popped into the frame word W. If the FIFO is empty, W=0x0000 and `underrun` is set.
  - `new_frame` = 1 for exactly that clk cycle. This applies in RUN only.
- Data format (standard I2S, one-bclk delay):
  - `i2s_lrclk` = 0 for bit_cnt 0..15 and 1 for bit_cnt 16..31.
  - bit_cnt 1..16: W[15]..W[0] (left slot).
  - bit_cnt 17..31: W[15]..W[1] (right slot).
  - bit_cnt 0 of the next frame: W[0].
  - On the first frame after IDLE, bit 0 carries 0.
- FIFO:
  - 4 entries, first-in first-out.
  - A push with `sample_valid`=1 when level<4 stores `sample_in`.
  - A push when level=4 is dropped, the contents are unchanged, and `overflow` is set.
  - Push and pop in the same cycle:
    - Pop is evaluated first, so a full FIFO accepts the push (level stays 4, no overflow).
    - An empty FIFO does not bypass: the pop underruns and the push is stored, giving level 1.
- `clear_flags`=1 clears `underrun` and `overflow`. A set event in the same cycle wins.
- `sample_valid` is accepted in every state, including IDLE.

## Timing
- All outputs are registered and update one edge after the event that causes them.
- `i2s_bclk`, `i2s_lrclk` and `i2s_sdata` change on the same clk edge. Data and LRCLK change only on BCLK falling edges and are stable across the rising edge.
- The frame-start edge does all of the following together: drives `i2s_bclk` low, `i2s_lrclk`=0, `i2s_sdata`=previous W[0], `new_frame`=1, and the `fifo_level` decrement.
- BCLK period = 2·BCLK_DIV clk cycles. `new_frame` period = 64·BCLK_DIV clk cycles in steady RUN.
- Latency from push to first serialised bit is at most (level+1) frames.
- An asynchronous reset in mid-frame immediately forces all outputs to 0 and the FSM to IDLE. No partial frame resumes after reset.

## Test plan
- Reset, then `enable`=1 with an empty FIFO, BCLK_DIV=4:
  - `new_frame` pulses every 256 clk cycles.
  - `i2s_sdata` stays 0.
  - `underrun`=1 after the first frame; `clear_flags` returns it to 0.
- Push 0xA5C3, then `enable`=1:
  - Left slot bits 1..16 = 1010_0101_1100_0011.
  - Right slot = the same word, with its LSB at bit 0 of the next frame.
  - `i2s_lrclk` rises at bit 16.
  - `fifo_level` goes 1 → 0.
- Push 5 samples back-to-back while in IDLE:
  - `fifo_level`=4, `overflow`=1.
  - The 5th sample is absent from the output order.
- Full FIFO, `sample_valid` coincident with a frame-start pop:
  - `fifo_level` stays 4, `overflow` stays 0.
  - The pushed sample comes out 4 frames later.
- Drop `enable` at bit_cnt 10:
  - The frame completes through bit 31.
  - Then no `new_frame`, BCLK/LRCLK/SDATA held 0, FSM in IDLE.
  - Re-raising `enable` during STOP gives a gapless stream.
- Bench loop mimicking the decoder: each `new_frame` answered 5 clk later by `sample_valid` with an incrementing sample, plus an async reset asserted mid-frame:
  - No underrun or overflow in steady state.
  - Outputs 0 immediately on reset.
  - Restart begins with a fresh frame at bit_cnt 0.

Source files
------------

// File: rtl/i2s_sample_tx.sv
// Mono 16-bit I2S transmitter fed by a 4-deep sample FIFO; one word per frame,
// duplicated on both channels, with a one-cycle new_frame request upstream.
module i2s_sample_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    input  logic        clear_flags,
    output logic        new_frame,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic [2:0]  fifo_level,
    output logic        underrun,
    output logic        overflow
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOP
    } state_t;

    state_t            state_reg, state_next;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic              bclk_reg;
    logic [4:0]        bit_cnt_reg;
    logic [15:0]       shift_reg;
    logic              lrclk_reg;
    logic              sdata_reg;
    logic              new_frame_reg;
    logic              underrun_reg;
    logic              overflow_reg;

    logic [15:0]       fifo_mem [4];
    logic [1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [2:0]        level_reg;

    logic              div_tc;
    logic              fall_tick;
    logic              run_eff;
    logic              frame_start;
    logic              go_idle;
    logic [4:0]        bit_next;
    logic              fifo_empty, fifo_full;
    logic              pop, push;
    logic [15:0]       head;
    logic              underrun_set, overflow_set;

    assign div_tc   = (div_cnt_reg == DIV_LAST);
    assign bit_next = bit_cnt_reg + 5'd1;
    // STOP with enable re-asserted behaves exactly like RUN, so the stream never gaps.
    assign run_eff  = (state_reg == ST_RUN) || ((state_reg == ST_STOP) && enable);

    always_comb begin
        state_next  = state_reg;
        frame_start = 1'b0;
        go_idle     = 1'b0;
        fall_tick   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    state_next  = ST_RUN;
                    frame_start = 1'b1;
                end
            end
            ST_RUN, ST_STOP: begin
                state_next = enable ? ST_RUN : ST_STOP;
                fall_tick  = div_tc && bclk_reg;
                if (fall_tick && (bit_cnt_reg == 5'd31)) begin
                    if (run_eff) begin
                        frame_start = 1'b1;
                    end else begin
                        go_idle    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pop is resolved before push: a full FIFO can accept a push at a pop, an empty one never bypasses.
    always_comb begin
        fifo_empty   = (level_reg == 3'd0);
        fifo_full    = (level_reg == 3'd4);
        pop          = frame_start && !fifo_empty;
        push         = sample_valid && (!fifo_full || pop);
        head         = pop ? fifo_mem[rd_ptr_reg] : 16'h0000;
        underrun_set = frame_start && fifo_empty;
        overflow_set = sample_valid && fifo_full && !pop;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            underrun_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            level_reg    <= level_reg + {2'b00, push} - {2'b00, pop};
            underrun_reg <= underrun_set | (underrun_reg & ~clear_flags);
            overflow_reg <= overflow_set | (overflow_reg & ~clear_flags);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            div_cnt_reg   <= '0;
            bclk_reg      <= 1'b0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            lrclk_reg     <= 1'b0;
            sdata_reg     <= 1'b0;
            new_frame_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            new_frame_reg <= frame_start;
            if ((state_reg == ST_IDLE) || go_idle) begin
                div_cnt_reg <= '0;
                bclk_reg    <= 1'b0;
                bit_cnt_reg <= '0;
                lrclk_reg   <= 1'b0;
                sdata_reg   <= 1'b0;
                shift_reg   <= frame_start ? head : 16'h0000;
            end else begin
                div_cnt_reg <= div_tc ? '0 : div_cnt_reg + DIV_W'(1);
                if (div_tc) begin
                    bclk_reg <= ~bclk_reg;
                end
                // Left-rotate: after 16 shifts the word is back in place for the right slot,
                // and after 31 its LSB sits on top ready for bit 0 of the next frame.
                if (fall_tick) begin
                    bit_cnt_reg <= bit_next;
                    lrclk_reg   <= bit_next[4];
                    sdata_reg   <= shift_reg[15];
                    shift_reg   <= frame_start ? head : {shift_reg[14:0], shift_reg[15]};
                end
            end
        end
    end

    assign new_frame  = new_frame_reg;
    assign i2s_bclk   = bclk_reg;
    assign i2s_lrclk  = lrclk_reg;
    assign i2s_sdata  = sdata_reg;
    assign fifo_level = level_reg;
    assign underrun   = underrun_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Scoreboard bench for i2s_sample_tx: a frame-arithmetic reference model queues the
// expected outputs each clock and a separate monitor compares them on the falling edge.
module tb_i2s_sample_tx;

    localparam int DIV   = 4;
    localparam int FRAME = 64 * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic        sample_valid = 1'b0;
    logic        clear_flags = 1'b0;
    logic        new_frame, i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overflow;
    logic [2:0]  fifo_level;

    int compared = 0;
    int mismatched = 0;
    logic [15:0] dec_val = 16'h0000;

    typedef struct packed {
        logic       nf;
        logic       bclk;
        logic       lr;
        logic       sd;
        logic [2:0] lvl;
        logic       ur;
        logic       ov;
    } obs_t;

    obs_t exp_q[$];

    // Reference model state: sample queue, current frame word, clocks since frame start.
    logic [15:0] m_q[$];
    logic [15:0] m_word = 16'h0000;
    bit          m_active = 1'b0;
    bit          m_prev_en = 1'b0;
    bit          m_prev_lsb = 1'b0;
    bit          m_ur = 1'b0;
    bit          m_ov = 1'b0;
    int          m_n = 0;

    always #5 clk = ~clk;

    i2s_sample_tx #(.BCLK_DIV(DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear_flags  (clear_flags),
        .new_frame    (new_frame),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .overflow     (overflow)
    );

    // Serial bit for I2S bit slot b: bit 0 carries the previous word's LSB.
    function automatic logic exp_sd(input int b, input logic [15:0] w, input logic lsb);
        if (b == 0)
            return lsb;
        else if (b <= 16)
            return w[16 - b];
        else
            return w[32 - b];
    endfunction

    always @(posedge clk) begin : model_blk
        obs_t e;
        bit   fs, ur_set, ov_set;
        int   half, b;
        e = '0;
        fs = 1'b0;
        ur_set = 1'b0;
        ov_set = 1'b0;
        if (!reset) begin
            m_q.delete();
            m_word = 16'h0000;
            m_active = 1'b0;
            m_prev_en = 1'b0;
            m_prev_lsb = 1'b0;
            m_ur = 1'b0;
            m_ov = 1'b0;
            m_n = 0;
        end else begin
            if (!m_active) begin
                if (enable) begin
                    m_active = 1'b1;
                    m_n = 0;
                    fs = 1'b1;
                    m_prev_lsb = 1'b0;
                end
            end else begin
                m_n++;
                if (m_n == FRAME) begin
                    m_n = 0;
                    // Stop only when enable has been low at this edge and the one before.
                    if (!m_prev_en && !enable) begin
                        m_active = 1'b0;
                    end else begin
                        fs = 1'b1;
                        m_prev_lsb = m_word[0];
                    end
                end
            end
            m_prev_en = enable;
            if (fs) begin
                if (m_q.size() > 0) begin
                    m_word = m_q.pop_front();
                end else begin
                    m_word = 16'h0000;
                    ur_set = 1'b1;
                end
            end
            if (sample_valid) begin
                if (m_q.size() < 4) m_q.push_back(sample_in);
                else ov_set = 1'b1;
            end
            m_ur = ur_set | (m_ur & !clear_flags);
            m_ov = ov_set | (m_ov & !clear_flags);
            e.nf  = fs;
            e.lvl = 3'(m_q.size());
            e.ur  = m_ur;
            e.ov  = m_ov;
            if (m_active) begin
                half   = m_n / DIV;
                b      = half / 2;
                e.bclk = (half % 2) == 1;
                e.lr   = (b >= 16);
                e.sd   = exp_sd(b, m_word, m_prev_lsb);
            end
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor_blk
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {new_frame, i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level, underrun, overflow};
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL outputs @%0t: actual nf=%b bclk=%b lr=%b sd=%b lvl=%0d ur=%b ov=%b, required nf=%b bclk=%b lr=%b sd=%b lvl=%0d ur=%b ov=%b",
                         $time, a.nf, a.bclk, a.lr, a.sd, a.lvl, a.ur, a.ov,
                         e.nf, e.bclk, e.lr, e.sd, e.lvl, e.ur, e.ov);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [15:0] v);
        sample_in = v;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
    endtask

    // Decoder stand-in: answer each new_frame five clocks later with the next sample.
    task automatic decode(input int frames);
        for (int f = 0; f < frames; f++) begin
            int t;
            t = 0;
            while (new_frame !== 1'b1 && t < 2 * FRAME) begin
                step();
                t++;
            end
            compared++;
            if (new_frame !== 1'b1) begin
                mismatched++;
                $display("FAIL new_frame_wait: no pulse after %0d cycles, required one within %0d", t, 2 * FRAME);
                return;
            end
            repeat (5) step();
            push(dec_val);
            dec_val = dec_val + 16'd1;
        end
    endtask

    initial begin
        // Reset state.
        reset = 1'b0;
        repeat (3) step();
        check("reset_level", {13'd0, fifo_level}, 16'd0);
        reset = 1'b1;
        step();

        // Empty FIFO: silent stream, underrun each frame, clearable.
        enable = 1'b1;
        repeat (3 * FRAME + 20) step();
        check("underrun_set", {15'd0, underrun}, 16'd1);
        pulse_clear();
        repeat (10) step();
        check("underrun_cleared", {15'd0, underrun}, 16'd0);
        enable = 1'b0;
        repeat (2 * FRAME) step();

        // Single known word.
        push(16'hA5C3);
        check("level_one", {13'd0, fifo_level}, 16'd1);
        enable = 1'b1;
        repeat (2 * FRAME) step();
        enable = 1'b0;
        repeat (2 * FRAME) step();

        // Five back-to-back pushes in IDLE: fifth is dropped.
        pulse_clear();
        sample_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_in = 16'($urandom);
            step();
        end
        sample_valid = 1'b0;
        step();
        check("level_full", {13'd0, fifo_level}, 16'd4);
        check("overflow_set", {15'd0, overflow}, 16'd1);
        enable = 1'b1;
        repeat (6 * FRAME) step();
        enable = 1'b0;
        repeat (2 * FRAME) step();

        // Full FIFO with a push coincident with the entry pop.
        pulse_clear();
        for (int i = 0; i < 4; i++) push(16'($urandom));
        enable = 1'b1;
        sample_in = 16'($urandom);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        check("level_stays_full", {13'd0, fifo_level}, 16'd4);
        check("overflow_clear", {15'd0, overflow}, 16'd0);
        repeat (6 * FRAME) step();
        enable = 1'b0;
        repeat (2 * FRAME) step();

        // Drop enable at bit 10, then a STOP interrupted by re-enable.
        push(16'($urandom));
        enable = 1'b1;
        repeat (10 * 2 * DIV + 2) step();
        enable = 1'b0;
        repeat (2 * FRAME) step();
        check("idle_bclk", {15'd0, i2s_bclk}, 16'd0);
        push(16'($urandom));
        push(16'($urandom));
        enable = 1'b1;
        repeat (FRAME + 10 * 2 * DIV) step();
        enable = 1'b0;
        repeat (10 * 2 * DIV) step();
        enable = 1'b1;
        repeat (2 * FRAME) step();
        enable = 1'b0;
        repeat (2 * FRAME) step();

        // Random traffic.
        repeat (8) begin
            enable = 1'($urandom_range(0, 1));
            repeat ($urandom_range(50, 600)) begin
                sample_valid = ($urandom_range(0, 99) < 3);
                sample_in = 16'($urandom);
                clear_flags = ($urandom_range(0, 199) == 0);
                step();
            end
        end
        sample_valid = 1'b0;
        clear_flags = 1'b0;
        enable = 1'b0;
        repeat (2 * FRAME) step();

        // Decoder loop, steady state, then an asynchronous reset mid-frame.
        pulse_clear();
        dec_val = 16'($urandom);
        enable = 1'b1;
        decode(4);
        pulse_clear();
        decode(4);
        check("steady_underrun", {15'd0, underrun}, 16'd0);
        check("steady_overflow", {15'd0, overflow}, 16'd0);
        repeat (100) step();
        reset = 1'b0;
        #1;
        check("async_reset_outputs",
              {7'd0, new_frame, i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level, underrun, overflow}, 16'd0);
        repeat (3) step();
        reset = 1'b1;
        decode(4);
        enable = 1'b0;
        repeat (2 * FRAME) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "time limit");
    end

endmodule
